adc_waveform_capture: RTL and testbench
=======================================

// Module: adc_waveform_capture
// PURPOSE
//  Upstream capture stage of the ADC->UART path. Holds a trigger-aligned window of N_SAMPLES ADC
//  samples with PRETRIG pre-trigger history, then drives the acquire code that starts serialisation.
//  Feeds the UART serialiser with waveform[], waveNumber and acquire; the FIR path is supplied elsewhere.
// PARAMETERS
//  N_SAMPLES   1000   capture window length in samples
//  SAMPLE_W    14     ADC sample width in bits
//  PRETRIG     100    samples kept before trigger; legal range 1..N_SAMPLES-1
//  SEND_CYCLES 36100  clk cycles acquire holds the send code; must be >= 36*N_SAMPLES+36
// PORTS
//  clk         in   1         capture and serialiser clock
//  rst_n       in   1         asynchronous active-low reset
//  adc_data    in   SAMPLE_W  ADC sample, unsigned
//  adc_valid   in   1         adc_data is valid this cycle
//  arm         in   1         one-cycle pulse; starts a capture from IDLE
//  fir_mode    in   1         1: send code 2'b01 (raw+FIR); 0: send code 2'b10 (raw only)
//  trig_level  in   SAMPLE_W  trigger threshold
//  trig_rising in   1         1: rising-edge trigger; 0: falling-edge trigger
//  waveform    out  SAMPLE_W x N_SAMPLES  unpacked array; [0] = oldest sample, [PRETRIG] = trigger sample
//  waveNumber  out  16        count of completed captures
//  acquire     out  2         2'b11 = hold/reset serialiser; 2'b10 or 2'b01 = send
//  busy        out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, waveform all 0, waveNumber 0, acquire 2'b11, busy 0, counters 0.
//  Buffer: shift register. On each accepted sample: waveform[i] <= waveform[i+1]; [N-1] <= adc_data.
//   A sample is accepted only when adc_valid=1 and state is FILL, WAIT or POST; otherwise the buffer is frozen.
//  FSM:
//   IDLE: acquire=11. On arm=1: latch fir_mode and trig_rising, clear cnt, go to FILL.
//   FILL: accept samples; cnt++ per accepted sample. At cnt==PRETRIG go to WAIT. Triggers are ignored.
//   WAIT: accept samples. prev = last accepted sample.
//    Rising trigger: prev < trig_level && adc_data >= trig_level. Falling trigger: prev > trig_level && adc_data <= trig_level.
//    On a trigger (valid sample only), that sample is shifted in; clear cnt; go to POST.
//   POST: accept samples. After N_SAMPLES-PRETRIG-1 more accepted samples, go to SEND (trigger sample lands at [PRETRIG]).
//    On entering SEND: waveNumber <= waveNumber+1, wrapping 16'hFFFF -> 0.
//   SEND: acquire = latched fir_mode ? 2'b01 : 2'b10 for exactly SEND_CYCLES cycles; buffer frozen; then go to IDLE.
//  acquire=11 in all states except SEND; acquire is registered and changes on the state-entry edge.
//  arm while busy: ignored. trig_level may change anytime; it is used combinationally in WAIT.
//  adc_valid=0: all counters and state hold; no trigger is evaluated.
//  Window is 1 sample ahead of pretrigger only if the trigger condition holds on the first WAIT sample; this is legal.
//  rst_n asserted mid-operation: immediate abort to reset values; the serialiser sees acquire=11 and restarts.
//  Counters are $clog2(max(N_SAMPLES,SEND_CYCLES))+1 bits; no other arithmetic overflows.
// CONFIGURATION
//  AUTO_REARM_EN defined: SEND exits to FILL (clear cnt, keep latched mode) instead of IDLE, giving
//   continuous captures; arm is still required for the first capture only.
//  AUTO_REARM_EN undefined: SEND exits to IDLE; each capture needs an arm pulse.
// STRUCTURE
//  Package capture_pkg:
//   state_t enum {IDLE,FILL,WAIT,POST,SEND}
//   ACQ_HOLD=2'b11, ACQ_RAW=2'b10, ACQ_FIR=2'b01
//   UART_BITS_PER_SAMPLE=36
//  Sub-module trigger_detect: prev register plus edge compare; outputs a one-cycle trig pulse qualified by adc_valid.
// TESTING
//  Ramp adc_data 0..4095 each cycle, level 2000, rising, arm once -> waveform[100]==2000,
//   [0]==1900, [999]==2899; waveNumber==1; acquire==2'b10 for 36100 cycles, then 11.
//  fir_mode=1, falling edge, level 500 on a descending ramp -> acquire==2'b01 in SEND; waveform[100]==500.
//  adc_valid toggling 50% during POST -> window is identical to the contiguous-valid case;
//   SEND entry is delayed by the number of idle cycles.
//  Signal above level during FILL (crossing at cnt=50) -> no trigger; first crossing in WAIT is used.
//  rst_n pulsed low mid-POST -> acquire==11, busy==0, waveNumber==0 on the same edge; arm then captures normally.
//  AUTO_REARM_EN defined, periodic ramp -> 3 back-to-back SENDs with no arm; waveNumber 1,2,3;
//   preload waveNumber=16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/adc_waveform_capture_pkg.sv
// capture_pkg: shared types and constants for the ADC waveform capture stage.
//   state_t               capture FSM states
//   ACQ_HOLD/RAW/FIR      acquire codes seen by the UART serialiser
//   UART_BITS_PER_SAMPLE  serialiser bits per sample; SEND_CYCLES must cover
//                         UART_BITS_PER_SAMPLE*(N_SAMPLES+1) clocks
//   cnt_width()           width of the shared sample/send counter
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT,
        POST,
        SEND
    } state_t;

    localparam logic [1:0] ACQ_HOLD = 2'b11;
    localparam logic [1:0] ACQ_RAW  = 2'b10;
    localparam logic [1:0] ACQ_FIR  = 2'b01;

    localparam int UART_BITS_PER_SAMPLE = 36;

    // One counter serves FILL, POST and SEND, so it must hold the larger of
    // the window length and the send duration, plus one bit of headroom.
    function automatic int cnt_width(input int n_samples, input int send_cycles);
        return $clog2((n_samples > send_cycles) ? n_samples : send_cycles) + 1;
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// trigger_detect: level-crossing trigger for the capture FSM.
//   clk, rst_n   clock, async active-low reset
//   adc_data     current ADC sample
//   adc_valid    adc_data valid this cycle
//   accept       the capture buffer takes adc_data this cycle (updates prev)
//   trig_level   threshold, used combinationally
//   rising       1: rising crossing, 0: falling crossing
//   trig         one-cycle pulse, only ever high together with adc_valid
module trigger_detect #(
    parameter int SAMPLE_W = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                rising,
    output logic                trig
);

    // prev tracks the last sample the buffer accepted, so a crossing is
    // always judged against the sample that sits next to it in the window.
    logic [SAMPLE_W-1:0] prev;
    logic                rise_hit;
    logic                fall_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= '0;
        else if (accept)
            prev <= adc_data;
    end

    assign rise_hit = (prev < trig_level) && (adc_data >= trig_level);
    assign fall_hit = (prev > trig_level) && (adc_data <= trig_level);
    assign trig     = adc_valid && (rising ? rise_hit : fall_hit);

endmodule

// File: rtl/adc_waveform_capture.sv
// adc_waveform_capture: trigger-aligned ADC capture window feeding the UART
// serialiser.
//   clk, rst_n   clock, async active-low reset
//   adc_data     unsigned ADC sample, adc_valid qualifies it
//   arm          one-cycle pulse starting a capture from IDLE
//   fir_mode     1: send code 2'b01 (raw+FIR), 0: 2'b10 (raw only); latched on arm
//   trig_level   trigger threshold (live)
//   trig_rising  1: rising trigger, 0: falling; latched on arm
//   waveform     N_SAMPLES window, [0] oldest, [PRETRIG] trigger sample
//   waveNumber   completed-capture count, wraps at 16 bits
//   acquire      11 hold serialiser, 10/01 send
//   busy         high outside IDLE
// Build option: AUTO_REARM_EN makes SEND restart FILL instead of returning
// to IDLE, so only the first capture needs an arm pulse.
module adc_waveform_capture
    import capture_pkg::*;
#(
    parameter int N_SAMPLES   = 1000,
    parameter int SAMPLE_W    = 14,
    parameter int PRETRIG     = 100,
    parameter int SEND_CYCLES = 36100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                arm,
    input  logic                fir_mode,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    output logic [SAMPLE_W-1:0] waveform [N_SAMPLES],
    output logic [15:0]         waveNumber,
    output logic [1:0]          acquire,
    output logic                busy
);

    localparam int CNT_W    = cnt_width(N_SAMPLES, SEND_CYCLES);
    // Samples still needed after the trigger so it lands at [PRETRIG].
    localparam int POST_LEN = N_SAMPLES - PRETRIG - 1;

    localparam logic [CNT_W-1:0] PRE_C     = CNT_W'(PRETRIG);
    localparam logic [CNT_W-1:0] POST_C    = CNT_W'(POST_LEN);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              fir_l;
    logic              rising_l;
    logic              accept;
    logic              trig;

    assign accept  = adc_valid && ((state == FILL) || (state == WAIT) || (state == POST));
    assign cnt_inc = cnt + 1'b1;

    trigger_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .accept     (accept),
        .trig_level (trig_level),
        .rising     (rising_l),
        .trig       (trig)
    );

    // Window shift register: oldest at [0], newest at [N_SAMPLES-1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SAMPLES; i++)
                waveform[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_SAMPLES - 1; i++)
                waveform[i] <= waveform[i+1];
            waveform[N_SAMPLES-1] <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acquire    <= ACQ_HOLD;
            busy       <= 1'b0;
            waveNumber <= '0;
            fir_l      <= 1'b0;
            rising_l   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        fir_l    <= fir_mode;
                        rising_l <= trig_rising;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end

                // Pre-trigger history; crossings here are deliberately ignored.
                FILL: begin
                    if (adc_valid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == PRE_C)
                            state <= WAIT;
                    end
                end

                WAIT: begin
                    if (trig) begin
                        cnt <= '0;
                        if (POST_LEN == 0) begin
                            // PRETRIG = N_SAMPLES-1: the trigger sample completes the window.
                            state      <= SEND;
                            acquire    <= fir_l ? ACQ_FIR : ACQ_RAW;
                            waveNumber <= waveNumber + 16'd1;
                        end else begin
                            state <= POST;
                        end
                    end
                end

                POST: begin
                    if (adc_valid) begin
                        if (cnt_inc == POST_C) begin
                            cnt        <= '0;
                            state      <= SEND;
                            acquire    <= fir_l ? ACQ_FIR : ACQ_RAW;
                            waveNumber <= waveNumber + 16'd1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                // cnt counts send clocks; the code is held for SEND_CYCLES clocks.
                SEND: begin
                    if (cnt == SEND_LAST) begin
                        cnt     <= '0;
                        acquire <= ACQ_HOLD;
`ifdef AUTO_REARM_EN
                        state   <= FILL;
`else
                        state   <= IDLE;
                        busy    <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    acquire <= ACQ_HOLD;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_waveform_capture.sv
// Directed bench for adc_waveform_capture with a short window
// (N=16, PRETRIG=4, SEND_CYCLES=36*17=612) so every phase is reachable quickly.
module tb_adc_waveform_capture;

    localparam int N    = 16;
    localparam int SW   = 14;
    localparam int PRE  = 4;
    localparam int SEND = 612;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] adc_data;
    logic          adc_valid;
    logic          arm;
    logic          fir_mode;
    logic [SW-1:0] trig_level;
    logic          trig_rising;
    logic [SW-1:0] wf [N];
    logic [15:0]   wave_num;
    logic [1:0]    acquire;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_waveform_capture #(
        .N_SAMPLES   (N),
        .SAMPLE_W    (SW),
        .PRETRIG     (PRE),
        .SEND_CYCLES (SEND)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .arm         (arm),
        .fir_mode    (fir_mode),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .waveform    (wf),
        .waveNumber  (wave_num),
        .acquire     (acquire),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input logic vld);
        adc_data  = SW'(v);
        adc_valid = vld;
        tick();
    endtask

    task automatic do_arm(input logic fm, input logic rise, input int lvl);
        fir_mode    = fm;
        trig_rising = rise;
        trig_level  = SW'(lvl);
        adc_valid   = 1'b0;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
    endtask

    task automatic wait_send_exit(input string tag);
        int n;
        n = 0;
        adc_valid = 1'b0;
        while (acquire !== 2'b11 && n < SEND + 10) begin
            tick();
            n++;
        end
        chk(tag, acquire, 2'b11);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; arm = 1'b0;
        fir_mode = 1'b0; trig_level = '0; trig_rising = 1'b1;
        tick(); tick();
        chk("rst_acquire", acquire, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_wavenum", wave_num, 0);
        chk("rst_wf0", wf[0], 0);
        chk("rst_wf15", wf[15], 0);
        rst_n = 1'b1;
        tick();

        // IDLE must not take samples.
        drive(77, 1'b1); drive(78, 1'b1);
        chk("idle_frozen", wf[15], 0);

        // 1: rising ramp through 2000, raw mode.
        do_arm(1'b0, 1'b1, 2000);
        chk("arm_busy", busy, 1);
        chk("arm_acq_hold", acquire, 2'b11);
        for (int v = 1990; v <= 2010; v++) drive(v, 1'b1);
        chk("t1_post_acq", acquire, 2'b11);
        drive(2011, 1'b1);
        chk("t1_acq_raw", acquire, 2'b10);
        chk("t1_wavenum", wave_num, 1);
        chk("t1_wf_trig", wf[PRE], 2000);
        chk("t1_wf0", wf[0], 1996);
        chk("t1_wf15", wf[15], 2011);
        // arm and samples during SEND are ignored; measure SEND length.
        arm = 1'b1; adc_data = 14'd9999; adc_valid = 1'b1;
        n = 1;
        tick();
        arm = 1'b0;
        if (acquire === 2'b10) n++;
        while (acquire === 2'b10 && n < SEND + 10) begin
            tick();
            if (acquire === 2'b10) n++;
        end
        chk("t1_send_len", n, SEND);
        chk("t1_send_exit", acquire, 2'b11);
        adc_valid = 1'b0;
`ifdef AUTO_REARM_EN
        chk("ar_busy", busy, 1);
        for (int v = 1990; v <= 2011; v++) drive(v, 1'b1);
        chk("ar_acq", acquire, 2'b10);
        chk("ar_wavenum", wave_num, 2);
        chk("ar_wf_trig", wf[PRE], 2000);
`else
        chk("t1_idle_busy", busy, 0);
        chk("t1_frozen", wf[15], 2011);

        // 2: falling ramp through 500, FIR mode.
        do_arm(1'b1, 1'b0, 500);
        for (int v = 510; v >= 489; v--) drive(v, 1'b1);
        chk("t2_acq_fir", acquire, 2'b01);
        chk("t2_wavenum", wave_num, 2);
        chk("t2_wf_trig", wf[PRE], 500);
        chk("t2_wf0", wf[0], 504);
        chk("t2_wf15", wf[15], 489);
        wait_send_exit("t2_send_exit");
        chk("t2_idle_busy", busy, 0);

        // 3: gaps in WAIT (with a crossing value while invalid) and in POST.
        do_arm(1'b0, 1'b1, 2000);
        for (int v = 1990; v <= 1996; v++) drive(v, 1'b1);
        drive(3000, 1'b0);
        for (int v = 1997; v <= 2000; v++) drive(v, 1'b1);
        for (int v = 2001; v <= 2010; v++) begin
            drive(v, 1'b1);
            drive(5000, 1'b0);
        end
        chk("t3_gap_acq_hold", acquire, 2'b11);
        drive(2011, 1'b1);
        chk("t3_acq_raw", acquire, 2'b10);
        chk("t3_wavenum", wave_num, 3);
        chk("t3_wf0", wf[0], 1996);
        chk("t3_wf_trig", wf[PRE], 2000);
        chk("t3_wf10", wf[10], 2006);
        chk("t3_wf15", wf[15], 2011);
        wait_send_exit("t3_send_exit");

        // 4: crossing inside FILL ignored, first WAIT crossing used.
        do_arm(1'b0, 1'b1, 1000);
        drive(900, 1'b1); drive(1100, 1'b1); drive(1200, 1'b1); drive(1300, 1'b1);
        drive(1400, 1'b1); drive(800, 1'b1); drive(1000, 1'b1);
        for (int v = 1001; v <= 1011; v++) drive(v, 1'b1);
        chk("t4_acq_raw", acquire, 2'b10);
        chk("t4_wavenum", wave_num, 4);
        chk("t4_wf0", wf[0], 1200);
        chk("t4_wf3", wf[3], 800);
        chk("t4_wf_trig", wf[PRE], 1000);
        chk("t4_wf15", wf[15], 1011);
        wait_send_exit("t4_send_exit");

        // 5: async reset in POST, then a normal capture.
        do_arm(1'b0, 1'b1, 2000);
        for (int v = 1990; v <= 2003; v++) drive(v, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_acq", acquire, 2'b11);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_wavenum", wave_num, 0);
        chk("t5_rst_wf_trig", wf[PRE], 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_arm(1'b0, 1'b1, 2000);
        for (int v = 1990; v <= 2011; v++) drive(v, 1'b1);
        chk("t5_acq_raw", acquire, 2'b10);
        chk("t5_wavenum", wave_num, 1);
        chk("t5_wf_trig", wf[PRE], 2000);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
